exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the 5-stage ARM pipeline, sitting directly downstream of the instruction decoder's control unit and the ID/EX register. It evaluates the instruction's condition field against the current status register, runs the 9-operation ALU selected by `exe_cmd`, updates the NZCV status register, and resolves branches. It then latches results and control into the EX/MEM pipeline register.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; `pc_in`, `val_rn`, `val2`, `val_rm`, `alu_result`, `st_val` and `branch_addr` are this width.

Ports (single clock; reset asynchronous, active-low):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `freeze` in 1: hold the EX/MEM register and the status register.
- `valid_in` in 1: the instruction in ID/EX is real; 0 means bubble.
- `cond` in 4: ARM condition field.
- `exe_cmd` in 4: ALU command.
- `mem_r_en`, `mem_w_en`, `wb_en`, `s`, `b` in 1 each: decoded control.
- `pc_in` in WIDTH: address of this instruction + 4.
- `val_rn` in WIDTH: first operand.
- `val2` in WIDTH: shifter operand, already generated upstream.
- `val_rm` in WIDTH: store data.
- `imm24` in 24: signed branch word offset.
- `dest` in 4: destination register.
- `mem_r_en_q`, `mem_w_en_q`, `wb_en_q` out 1: registered, condition-qualified control.
- `alu_result_q` out WIDTH: registered ALU result or memory address.
- `st_val_q` out WIDTH: registered `val_rm`.
- `dest_q` out 4: registered destination.
- `status` out 4: registered {N,Z,C,V}.
- `branch_taken` out 1: combinational; high when the branch is executed.
- `branch_addr` out WIDTH: combinational; `pc_in + (sext(imm24) << 2)`, modulo 2^WIDTH.

## Operation
Condition evaluation:
- `exec` = `valid_in` & `cond_pass(cond, status)`.
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
- 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
- 1000 HI C&!Z; 1001 LS !C|Z.
- 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
- 1110 AL always; 1111 never.

ALU (a = `val_rn`, b = `val2`, Cin = status C; sum is 33 bits, carry = bit 32):
- 0001 MOV: b.
- 1001 MVN: ~b.
- 0010 ADD: a+b.
- 0011 ADC: a+b+Cin.
- 0100 SUB: a+~b+1.
- 0101 SBC: a+~b+Cin.
- 0110 AND; 0111 ORR; 1000 EOR.
- Any other code: result 0, no flag change.

Flag rules:
- N = result[WIDTH-1]; Z = (result == 0).
- Arithmetic ops: C = carry-out. V = operand sign bits equal (after inversion of b for SUB/SBC) and result sign differs.
- Logical and move ops: C and V preserved.

Status register update:
- Written when `exec & s & !b & !freeze`.
- Branches never alter flags, even with `s` = 1.

Branch:
- `branch_taken` = `exec & b`.
- `exe_cmd` is don't-care for branches; `alu_result_q` is then unspecified but `wb_en_q`, `mem_r_en_q` and `mem_w_en_q` are 0.

Memory-mode instructions:
- ALU performs ADD (address = a + b).
- `alu_result_q` carries the address.
- `st_val_q` carries `val_rm`.

EX/MEM register, when `!freeze`:
- `wb_en_q`, `mem_r_en_q`, `mem_w_en_q` capture their inputs ANDed with `exec`.
- Data fields capture unconditionally.
- A failed condition or bubble becomes a no-op with all enables 0.

## Timing
- Reset: all registered outputs and `status` are 0, asynchronously on `rst_n` low.
  - Held while low; first capture is on the first rising edge after release.
  - Reset mid-operation discards the in-flight instruction.
- Latency: 1 cycle from inputs to `*_q` outputs.
- Flags written at edge k are visible to the condition and Cin of the instruction presented in cycle k+1.
  - Back-to-back CMP then BEQ requires no stall.
- `branch_taken`/`branch_addr` are valid in the same cycle as the inputs; fetch and flush act on them upstream.
- `freeze` high:
  - EX/MEM and `status` hold.
  - `branch_taken` is forced 0 so a held branch is not double-issued.
  - Inputs are expected stable until `freeze` falls.
- `valid_in`=0 and `freeze`=1 together: freeze dominates; everything holds.

## Test plan
- Reset then ADD (cmd 0010), a=0x7FFFFFFF, b=1, s=1, cond AL:
  - next cycle `alu_result_q`=0x80000000, `status`=1001 (N,V).
- SUB a=5, b=5, s=1, then a BEQ with imm24=0xFFFFFE and pc_in=0x100 in the following cycle:
  - `status`=0110; `branch_taken`=1; `branch_addr`=0xF8.
- MOVNE with Z=1:
  - `wb_en_q`=0, `status` unchanged.
- Same MOVNE with Z=0:
  - `wb_en_q`=1, `alu_result_q`=val2.
- SBC a=0, b=0, Cin=0:
  - result 0xFFFFFFFF, flags N=1, C=0, V=0.
- ANDS result 0 with prior C=1, V=1:
  - `status`=0111.
- LDR a=0x400, b=8:
  - `alu_result_q`=0x408, `mem_r_en_q`=1.
- Assert `freeze` for 3 cycles: outputs hold and `branch_taken`=0.
- Pulse `rst_n` low mid-freeze: all outputs go to 0 immediately.

Source files
------------

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - ARM execute stage: condition check, ALU, NZCV flags, branch resolve, EX/MEM register
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             valid_in,
  input  logic [3:0]       cond,
  input  logic [3:0]       exe_cmd,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             wb_en,
  input  logic             s,
  input  logic             b,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] val_rm,
  input  logic [23:0]      imm24,
  input  logic [3:0]       dest,
  output logic             mem_r_en_q,
  output logic             mem_w_en_q,
  output logic             wb_en_q,
  output logic [WIDTH-1:0] alu_result_q,
  output logic [WIDTH-1:0] st_val_q,
  output logic [3:0]       dest_q,
  output logic [3:0]       status,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_addr
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  logic [3:0]       status_q, status_d;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             cond_pass, exec;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] b_op, result;
  logic             cin_op, arith, op_known, carry, ovf;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] br_off;

  assign {flag_n, flag_z, flag_c, flag_v} = status_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign exec = valid_in && cond_pass;

  // Loads and stores reuse the adder for address generation whatever exe_cmd says.
  assign op_sel = (mem_r_en || mem_w_en) ? CMD_ADD : exe_cmd;

  always_comb begin
    b_op   = val2;
    cin_op = 1'b0;
    arith  = 1'b0;
    case (op_sel)
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; cin_op = flag_c; end
      CMD_SUB: begin arith = 1'b1; b_op = ~val2; cin_op = 1'b1; end
      CMD_SBC: begin arith = 1'b1; b_op = ~val2; cin_op = flag_c; end
      default: ;
    endcase
  end

  assign sum = {1'b0, val_rn} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin_op};

  always_comb begin
    result   = '0;
    op_known = 1'b1;
    carry    = flag_c;
    ovf      = flag_v;
    case (op_sel)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_AND: result = val_rn & val2;
      CMD_ORR: result = val_rn | val2;
      CMD_EOR: result = val_rn ^ val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: result = sum[WIDTH-1:0];
      default: op_known = 1'b0;
    endcase
    if (arith) begin
      carry = sum[WIDTH];
      ovf   = (val_rn[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != val_rn[WIDTH-1]);
    end
  end

  assign status_d = {result[WIDTH-1], (result == '0), carry, ovf};

  // Branch offset is a signed word count, so sign-extend and scale by 4.
  assign br_off       = {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};
  assign branch_addr  = pc_in + br_off;
  assign branch_taken = exec && b && !freeze;
  assign status       = status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q     <= '0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      alu_result_q <= '0;
      st_val_q     <= '0;
      dest_q       <= '0;
    end else if (!freeze) begin
      mem_r_en_q   <= mem_r_en && exec && !b;
      mem_w_en_q   <= mem_w_en && exec && !b;
      wb_en_q      <= wb_en && exec && !b;
      alu_result_q <= result;
      st_val_q     <= val_rm;
      dest_q       <= dest;
      if (exec && s && !b && op_known) status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed and randomized checks of exe_stage against a behavioural model
module tb_exe_stage;
  logic        clk = 1'b0;
  logic        rst_n, freeze, valid_in, mem_r_en, mem_w_en, wb_en, s, b;
  logic [3:0]  cond, exe_cmd, dest;
  logic [31:0] pc_in, val_rn, val2, val_rm;
  logic [23:0] imm24;
  logic        mem_r_en_q, mem_w_en_q, wb_en_q, branch_taken;
  logic [31:0] alu_result_q, st_val_q, branch_addr;
  logic [3:0]  dest_q, status;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]  m_status;
  logic        m_wb, m_mr, m_mw, m_alu_chk;
  logic [31:0] m_alu, m_st;
  logic [3:0]  m_dest;

  always #5 clk = ~clk;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .valid_in(valid_in), .cond(cond),
    .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
    .s(s), .b(b), .pc_in(pc_in), .val_rn(val_rn), .val2(val2), .val_rm(val_rm),
    .imm24(imm24), .dest(dest), .mem_r_en_q(mem_r_en_q), .mem_w_en_q(mem_w_en_q),
    .wb_en_q(wb_en_q), .alu_result_q(alu_result_q), .st_val_q(st_val_q),
    .dest_q(dest_q), .status(status), .branch_taken(branch_taken),
    .branch_addr(branch_addr)
  );

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit nf = f[3], zf = f[2], cf = f[1], vf = f[0];
    case (c)
      0: return zf;              1: return !zf;
      2: return cf;              3: return !cf;
      4: return nf;              5: return !nf;
      6: return vf;              7: return !vf;
      8: return cf && !zf;       9: return !cf || zf;
      10: return nf == vf;       11: return nf != vf;
      12: return !zf && nf == vf; 13: return zf || nf != vf;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Returns {known, nzcv, result}; carry/overflow derived from true integer sums.
  function automatic logic [36:0] m_alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] bb, input logic [3:0] f);
    longint ua = longint'(a), ub = longint'(bb);
    longint sa = longint'($signed(a)), sb = longint'($signed(bb));
    longint ci = longint'(f[1]);
    longint us = 0, ss = 0;
    logic [31:0] r;
    bit known = 1, ar = 1, cc = f[1], vv = f[0];
    case (op)
      1: begin r = bb; ar = 0; end
      9: begin r = ~bb; ar = 0; end
      6: begin r = a & bb; ar = 0; end
      7: begin r = a | bb; ar = 0; end
      8: begin r = a ^ bb; ar = 0; end
      2: begin us = ua + ub; ss = sa + sb; end
      3: begin us = ua + ub + ci; ss = sa + sb + ci; end
      4: begin us = ua - ub; ss = sa - sb; end
      5: begin us = ua - ub - 1 + ci; ss = sa - sb - 1 + ci; end
      default: begin r = 0; ar = 0; known = 0; end
    endcase
    if (ar) begin
      r  = ss[31:0];
      vv = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      if (op == 2 || op == 3) cc = (us > 64'hFFFF_FFFF);
      else                    cc = (us >= 0);
    end
    return {known, r[31], (r == 0), cc, vv, r};
  endfunction

  task automatic model_edge();
    logic [36:0] rr;
    bit ex;
    if (freeze) return;
    ex = valid_in && m_cond(cond, m_status);
    rr = m_alu_fn((mem_r_en || mem_w_en) ? 4'd2 : exe_cmd, val_rn, val2, m_status);
    m_wb = wb_en && ex && !b;
    m_mr = mem_r_en && ex && !b;
    m_mw = mem_w_en && ex && !b;
    m_alu = rr[31:0];
    m_alu_chk = !b;
    m_st = val_rm;
    m_dest = dest;
    if (ex && s && !b && rr[36]) m_status = rr[35:32];
  endtask

  task automatic model_reset();
    m_status = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_alu = 0; m_st = 0; m_dest = 0; m_alu_chk = 1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] c, input logic [3:0] cmd, input logic ss, input logic bb,
                        input logic mr, input logic mw, input logic wb, input logic [31:0] a,
                        input logic [31:0] v2, input logic [31:0] pc, input logic [23:0] im);
    valid_in = 1; cond = c; exe_cmd = cmd; s = ss; b = bb; mem_r_en = mr; mem_w_en = mw;
    wb_en = wb; val_rn = a; val2 = v2; pc_in = pc; imm24 = im;
    val_rm = $urandom; dest = 4'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 0; freeze = 0;
    set_op(4'he, 4'h2, 1, 0, 1, 1, 1, 32'h1234, 32'h5678, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({mem_r_en_q, mem_w_en_q, wb_en_q, alu_result_q, st_val_q, dest_q, status} !== '0) begin
      n_err++; $display("FAIL reset_state: got %h want 0",
        {mem_r_en_q, mem_w_en_q, wb_en_q, alu_result_q, st_val_q, dest_q, status});
    end
    rst_n = 1;
  endtask

  task automatic test_add_overflow();
    set_op(4'he, 4'h2, 1, 0, 0, 0, 1, 32'h7FFF_FFFF, 32'h1, 0, 0);
    tick();
    n_vec++;
    if (alu_result_q !== 32'h8000_0000) begin
      n_err++; $display("FAIL add_result: got %h want 80000000", alu_result_q);
    end
    n_vec++;
    if (status !== 4'b1001) begin
      n_err++; $display("FAIL add_flags: got %b want 1001", status);
    end
  endtask

  task automatic test_cmp_beq();
    set_op(4'he, 4'h4, 1, 0, 0, 0, 0, 32'd5, 32'd5, 0, 0);
    tick();
    n_vec++;
    if (status !== 4'b0110) begin
      n_err++; $display("FAIL sub_flags: got %b want 0110", status);
    end
    set_op(4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 32'h100, 24'hFFFFFE);
    #1;
    n_vec++;
    if (branch_taken !== 1'b1) begin
      n_err++; $display("FAIL beq_taken: got %b want 1", branch_taken);
    end
    n_vec++;
    if (branch_addr !== 32'hF8) begin
      n_err++; $display("FAIL beq_addr: got %h want 000000f8", branch_addr);
    end
    tick();
    n_vec++;
    if ({wb_en_q, mem_r_en_q, mem_w_en_q} !== 3'b000) begin
      n_err++; $display("FAIL beq_enables: got %b want 000", {wb_en_q, mem_r_en_q, mem_w_en_q});
    end
  endtask

  task automatic test_movne();
    set_op(4'h1, 4'h1, 0, 0, 0, 0, 1, 0, 32'h1234, 0, 0);
    tick();
    n_vec++;
    if (wb_en_q !== 1'b0 || status !== 4'b0110) begin
      n_err++; $display("FAIL movne_z1: got wb=%b st=%b want wb=0 st=0110", wb_en_q, status);
    end
    set_op(4'he, 4'h2, 1, 0, 0, 0, 0, 32'd1, 32'd1, 0, 0);
    tick();
    set_op(4'h1, 4'h1, 0, 0, 0, 0, 1, 0, 32'hABCD, 0, 0);
    tick();
    n_vec++;
    if (wb_en_q !== 1'b1 || alu_result_q !== 32'hABCD) begin
      n_err++; $display("FAIL movne_z0: got wb=%b res=%h want wb=1 res=0000abcd", wb_en_q, alu_result_q);
    end
  endtask

  task automatic test_sbc();
    set_op(4'he, 4'h5, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    n_vec++;
    if (alu_result_q !== 32'hFFFF_FFFF || status !== 4'b1000) begin
      n_err++; $display("FAIL sbc: got res=%h st=%b want ffffffff 1000", alu_result_q, status);
    end
  endtask

  task automatic test_ands();
    set_op(4'he, 4'h2, 1, 0, 0, 0, 0, 32'h8000_0000, 32'h8000_0001, 0, 0);
    tick();
    n_vec++;
    if (status !== 4'b0011) begin
      n_err++; $display("FAIL ands_setup: got %b want 0011", status);
    end
    set_op(4'he, 4'h6, 1, 0, 0, 0, 1, 32'hF0, 32'h0F, 0, 0);
    tick();
    n_vec++;
    if (status !== 4'b0111 || alu_result_q !== 32'h0) begin
      n_err++; $display("FAIL ands: got st=%b res=%h want 0111 0", status, alu_result_q);
    end
  endtask

  task automatic test_ldr();
    set_op(4'he, 4'h2, 0, 0, 1, 0, 1, 32'h400, 32'h8, 0, 0);
    val_rm = 32'hDEAD_BEEF;
    tick();
    n_vec++;
    if (alu_result_q !== 32'h408 || mem_r_en_q !== 1'b1 || st_val_q !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL ldr: got addr=%h mr=%b st=%h want 408 1 deadbeef",
                        alu_result_q, mem_r_en_q, st_val_q);
    end
  endtask

  task automatic test_freeze();
    freeze = 1;
    set_op(4'h0, 4'h2, 1, 1, 0, 1, 1, 32'h1, 32'h1, 32'h200, 24'h10);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (branch_taken !== 1'b0) begin
        n_err++; $display("FAIL freeze_branch[%0d]: got %b want 0", i, branch_taken);
      end
      tick();
      n_vec++;
      if (alu_result_q !== 32'h408 || mem_r_en_q !== 1'b1 || status !== 4'b0111 ||
          st_val_q !== 32'hDEAD_BEEF) begin
        n_err++; $display("FAIL freeze_hold[%0d]: got addr=%h mr=%b st=%b want 408 1 0111",
                          i, alu_result_q, mem_r_en_q, status);
      end
    end
  endtask

  task automatic test_reset_mid_freeze();
    #2 rst_n = 0;
    model_reset();
    #1;
    n_vec++;
    if ({mem_r_en_q, mem_w_en_q, wb_en_q, alu_result_q, st_val_q, dest_q, status} !== '0) begin
      n_err++; $display("FAIL reset_mid_freeze: got %h want 0",
        {mem_r_en_q, mem_w_en_q, wb_en_q, alu_result_q, st_val_q, dest_q, status});
    end
    @(posedge clk);
    #1 rst_n = 1;
    freeze = 0;
  endtask

  task automatic test_random();
    logic        exp_bt;
    logic [31:0] exp_ba;
    int          off;
    for (int i = 0; i < 400; i++) begin
      set_op(4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
             0, 0, 1'($urandom), $urandom, $urandom, $urandom, 24'($urandom));
      valid_in = ($urandom_range(0, 7) != 0);
      freeze   = ($urandom_range(0, 9) == 0);
      if (i % 5 == 0) begin
        val2 = val_rn;
        cond = 4'he;
      end
      if (!b && $urandom_range(0, 4) == 0) begin
        s = 0;
        if ($urandom_range(0, 1) == 1) mem_r_en = 1; else mem_w_en = 1;
      end
      #1;
      off    = {{8{imm24[23]}}, imm24};
      exp_ba = pc_in + 32'(off * 4);
      exp_bt = !freeze && valid_in && b && m_cond(cond, m_status);
      n_vec++;
      if (branch_taken !== exp_bt || branch_addr !== exp_ba) begin
        n_err++; $display("FAIL rand_branch[%0d]: got %b %h want %b %h",
                          i, branch_taken, branch_addr, exp_bt, exp_ba);
      end
      tick();
      n_vec++;
      if (status !== m_status || wb_en_q !== m_wb || mem_r_en_q !== m_mr ||
          mem_w_en_q !== m_mw || st_val_q !== m_st || dest_q !== m_dest ||
          (m_alu_chk && alu_result_q !== m_alu)) begin
        n_err++; $display("FAIL rand_regs[%0d]: got st=%b wb=%b mr=%b mw=%b res=%h sv=%h d=%h want st=%b wb=%b mr=%b mw=%b res=%h sv=%h d=%h",
          i, status, wb_en_q, mem_r_en_q, mem_w_en_q, alu_result_q, st_val_q, dest_q,
          m_status, m_wb, m_mr, m_mw, m_alu, m_st, m_dest);
      end
    end
    freeze = 0;
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_add_overflow();
    test_cmp_beq();
    test_movne();
    test_sbc();
    test_ands();
    test_ldr();
    test_freeze();
    test_reset_mid_freeze();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
